muldiv_unit: RTL and testbench

//   Parametrised iterative multiply/divide unit with HI/LO result registers for the mcpu core.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 39 +++
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mdu_pkg: op and state encodings for the mul/div unit. Rev 1.0
// ------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ------------------------------------------------------------------
// mdu_step: one radix-2 shift-add (mul) or restoring-subtract (div) step. Rev 1.0
// ------------------------------------------------------------------
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] acc_hi_in,
  input  logic [WIDTH-1:0] acc_lo_in,
  output logic [WIDTH-1:0] acc_hi_out,
  output logic [WIDTH-1:0] acc_lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum        = {1'b0, acc_hi_in} + (acc_lo_in[0] ? {1'b0, operand} : '0);
    rem_sh     = {acc_hi_in, acc_lo_in[WIDTH-1]};
    diff       = rem_sh - {1'b0, operand};
    acc_hi_out = sum[WIDTH:1];
    acc_lo_out = {sum[0], acc_lo_in[WIDTH-1:1]};
    if (div_mode) begin
      // Remainder stays below the divisor, so the top bit of diff is a clean borrow flag.
      if (!diff[WIDTH]) begin
        acc_hi_out = diff[WIDTH-1:0];
        acc_lo_out = {acc_lo_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_out = rem_sh[WIDTH-1:0];
        acc_lo_out = {acc_lo_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// muldiv_unit: iterative multiply/divide with HI/LO registers and BUSY/DONE. Rev 1.0
// ------------------------------------------------------------------
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             div_op;
  logic             neg_q;
  logic             neg_r;

  logic             is_mul;
  logic             is_div;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_mode;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  logic [WIDTH-1:0] hi_c [0:BITS_PER_CYCLE];
  logic [WIDTH-1:0] lo_c [0:BITS_PER_CYCLE];

  always_comb begin
    is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
    is_div = (op == MDU_DIV)  || (op == MDU_DIVU);
    sa     = ((op == MDU_MULT) || (op == MDU_DIV)) && src_a[WIDTH-1];
    sb     = ((op == MDU_MULT) || (op == MDU_DIV)) && src_b[WIDTH-1];
    a_mag  = sa ? -src_a : src_a;
    b_mag  = sb ? -src_b : src_b;
  end

  assign div_mode = (state == S_DIV);
  assign hi_c[0]  = acc_hi;
  assign lo_c[0]  = acc_lo;

  generate
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_mode   (div_mode),
        .operand    (opnd),
        .acc_hi_in  (hi_c[i]),
        .acc_lo_in  (lo_c[i]),
        .acc_hi_out (hi_c[i+1]),
        .acc_lo_out (lo_c[i+1])
      );
    end
  endgenerate

  // Divide by zero forces an all-ones quotient regardless of operand signs;
  // the remainder path already reproduces the dividend.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = (opnd == '0) ? '1 : (neg_q ? -acc_lo : acc_lo);
    r_fix    = neg_r ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (run) begin
      done <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (is_mul || is_div) begin
                state  <= is_mul ? S_MUL : S_DIV;
                busy   <= 1'b1;
                cnt    <= '0;
                div_op <= is_div;
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                opnd   <= is_mul ? a_mag : b_mag;
                acc_hi <= '0;
                acc_lo <= is_mul ? b_mag : a_mag;
              end else if (op == MDU_MTHI) begin
                hi <= src_a;
              end else if (op == MDU_MTLO) begin
                lo <= src_a;
              end
            end
          end
          S_MUL, S_DIV: begin
            acc_hi <= hi_c[BITS_PER_CYCLE];
            acc_lo <= lo_c[BITS_PER_CYCLE];
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) state <= S_FIX;
          end
          S_FIX: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (div_op) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_muldiv_unit: directed scoreboard bench for two unit configurations (1 and 4 bits/cycle). Rev 1.0
// ------------------------------------------------------------------
module tb_muldiv_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        run_s   [2];
  logic        start_s [2];
  logic        abort_s [2];
  logic [2:0]  op_s    [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [31:0] hi_s    [2];
  logic [31:0] lo_s    [2];

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .run(run_s[0]), .start(start_s[0]), .op(op_s[0]),
    .src_a(a_s[0]), .src_b(b_s[0]), .abort(abort_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .hi(hi_s[0]), .lo(lo_s[0])
  );

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .run(run_s[1]), .start(start_s[1]), .op(op_s[1]),
    .src_a(a_s[1]), .src_b(b_s[1]), .abort(abort_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .hi(hi_s[1]), .lo(lo_s[1])
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse pops one expected {HI,LO} from that unit's queue.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (done_s[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_done dut%0d hi=%h lo=%h required=no DONE", d, hi_s[d], lo_s[d]);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("result_dut%0d", d), {hi_s[d], lo_s[d]}, e);
          end
        end
      end
    end
  end

  task automatic do_op(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e, input int stall_at, input int stall_len);
    int nexp;
    int cnt;
    nexp = ((d == 0) ? 33 : 9) + stall_len;
    cnt  = 0;
    @(negedge clk);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    start_s[d] = 1'b1;
    op_s[d]    = o;
    a_s[d]     = a;
    b_s[d]     = b;
    @(negedge clk);
    start_s[d] = 1'b0;
    op_s[d]    = MDU_NOP;
    while (busy_s[d] && cnt < 300) begin
      cnt++;
      if (stall_len > 0 && cnt == stall_at) run_s[d] = 1'b0;
      if (stall_len > 0 && cnt == stall_at + stall_len) run_s[d] = 1'b1;
      @(negedge clk);
    end
    run_s[d] = 1'b1;
    chk($sformatf("busy_cycles_dut%0d", d), 64'(cnt), 64'(nexp));
    chk($sformatf("done_pulse_dut%0d", d), 64'(done_s[d]), 64'd1);
    @(negedge clk);
    chk($sformatf("done_clear_dut%0d", d), 64'(done_s[d]), 64'd0);
  endtask

  task automatic mt_test(input int d);
    @(negedge clk);
    start_s[d] = 1'b1;
    op_s[d]    = MDU_MTHI;
    a_s[d]     = 32'hA5A5_A5A5;
    @(negedge clk);
    chk($sformatf("mthi_dut%0d", d), 64'(hi_s[d]), 64'hA5A5_A5A5);
    chk($sformatf("mthi_busy_dut%0d", d), 64'(busy_s[d]), 64'd0);
    op_s[d] = MDU_MTLO;
    a_s[d]  = 32'h5A5A_5A5A;
    @(negedge clk);
    start_s[d] = 1'b0;
    op_s[d]    = MDU_NOP;
    chk($sformatf("mtlo_dut%0d", d), {hi_s[d], lo_s[d]}, 64'hA5A5_A5A5_5A5A_5A5A);
    chk($sformatf("mtlo_busy_dut%0d", d), 64'(busy_s[d]), 64'd0);
    chk($sformatf("mt_done_dut%0d", d), 64'(done_s[d]), 64'd0);
  endtask

  // Starts DIVU 100/7, tries a MULT at cycle mc, aborts at cycle ac; HI/LO must keep MT values.
  task automatic abort_test(input int d, input int mc, input int ac);
    int c;
    @(negedge clk);
    start_s[d] = 1'b1;
    op_s[d]    = MDU_DIVU;
    a_s[d]     = 32'd100;
    b_s[d]     = 32'd7;
    @(negedge clk);
    start_s[d] = 1'b0;
    c = 1;
    while (c < ac) begin
      if (c == mc) begin
        start_s[d] = 1'b1;
        op_s[d]    = MDU_MULT;
        a_s[d]     = 32'd3;
        b_s[d]     = 32'd3;
      end else begin
        start_s[d] = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    start_s[d] = 1'b0;
    chk($sformatf("busy_before_abort_dut%0d", d), 64'(busy_s[d]), 64'd1);
    abort_s[d] = 1'b1;
    @(negedge clk);
    abort_s[d] = 1'b0;
    chk($sformatf("abort_busy_dut%0d", d), 64'(busy_s[d]), 64'd0);
    chk($sformatf("abort_done_dut%0d", d), 64'(done_s[d]), 64'd0);
    chk($sformatf("abort_hilo_dut%0d", d), {hi_s[d], lo_s[d]}, 64'hA5A5_A5A5_5A5A_5A5A);
    repeat (40) @(negedge clk);
    chk($sformatf("abort_idle_dut%0d", d), 64'(busy_s[d]), 64'd0);
    // ABORT together with START: the op must not be accepted.
    start_s[d] = 1'b1;
    abort_s[d] = 1'b1;
    op_s[d]    = MDU_DIV;
    @(negedge clk);
    start_s[d] = 1'b0;
    abort_s[d] = 1'b0;
    op_s[d]    = MDU_NOP;
    chk($sformatf("abort_start_dut%0d", d), 64'(busy_s[d]), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      run_s[d]   = 1'b1;
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
      op_s[d]    = MDU_NOP;
      a_s[d]     = '0;
      b_s[d]     = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_hilo_dut%0d", d), {hi_s[d], lo_s[d]}, 64'd0);
      chk($sformatf("reset_flags_dut%0d", d), {62'd0, busy_s[d], done_s[d]}, 64'd0);
    end
    reset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      do_op(d, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0);
      do_op(d, MDU_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
      do_op(d, MDU_DIVU,  32'd100,       32'd7,         {32'd2, 32'd14},         0, 0);
      do_op(d, MDU_DIV,   32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},  0, 0);
      do_op(d, MDU_DIV,   32'h0000_1234, 32'd0,         64'h0000_1234_FFFF_FFFF, 0, 0);
      do_op(d, MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0);
      do_op(d, MDU_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0);
      do_op(d, MDU_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 0, 0);
      mt_test(d);
      if (d == 0) abort_test(d, 5, 10);
      else        abort_test(d, 3, 6);
      do_op(d, MDU_MULTU, 32'h0001_2345, 32'h0001_0000, 64'h0000_0001_2345_0000, 3, 20);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty_dut0", 64'(q0.size()), 64'd0);
    chk("queue_empty_dut1", 64'(q1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
